// File: rtl/hgame_pkg.sv
// rtl/hgame_pkg.sv - shared winner codes, FSM states and score helpers
package hgame_pkg;

    localparam int SCORE_W = 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

    localparam logic [2:0] W_NONE = 3'b000;
    localparam logic [2:0] W_A    = 3'b100;
    localparam logic [2:0] W_B    = 3'b010;
    localparam logic [2:0] W_C    = 3'b001;
    localparam logic [2:0] W_DRAW = 3'b111;

    typedef enum logic [1:0] {
        S_READY = 2'd0,
        S_WAIT  = 2'd1,
        S_OVER  = 2'd2
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_next(input logic [SCORE_W-1:0] s,
                                                    input logic inc);
        return (inc && (s != SCORE_MAX)) ? s + 1'b1 : s;
    endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - round-result input and score/status output bundle
interface score_keeper_if #(parameter int RW = 6);
    logic [2:0]    WINNER_DISP;
    logic          NEW_MATCH;
    logic [3:0]    SCORE_A;
    logic [3:0]    SCORE_B;
    logic [3:0]    SCORE_C;
    logic [RW-1:0] ROUND_CNT;
    logic          ROUND_DONE;
    logic          MATCH_OVER;
    logic [2:0]    CHAMP;

    modport master (
        output WINNER_DISP, NEW_MATCH,
        input  SCORE_A, SCORE_B, SCORE_C, ROUND_CNT, ROUND_DONE, MATCH_OVER, CHAMP
    );

    modport slave (
        input  WINNER_DISP, NEW_MATCH,
        output SCORE_A, SCORE_B, SCORE_C, ROUND_CNT, ROUND_DONE, MATCH_OVER, CHAMP
    );
endinterface

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - per-player score counter, sync clear, saturates at 15
module sat_counter
    import hgame_pkg::*;
(
    input  logic               CLK,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] count
);

    always_ff @(posedge CLK) begin
        if (clr) begin
            count <= '0;
        end else begin
            count <= sat_next(count, inc);
        end
    end

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - counts each round result once, tracks scores and match winner
module score_keeper
    import hgame_pkg::*;
#(
    parameter int TARGET = 3,
    parameter int RW     = 6
) (
    input  logic           CLK,
    input  logic           RST,
    score_keeper_if.slave  sk
);

    localparam logic [SCORE_W-1:0] TGT = SCORE_W'(TARGET);

    state_t               state, state_n;
    logic [SCORE_W-1:0]   score_a, score_b, score_c;
    logic [RW-1:0]        round_cnt, round_cnt_n;
    logic                 round_done, round_done_n;
    logic                 match_over, match_over_n;
    logic [2:0]           champ, champ_n;
    logic [2:0]           inc_vec, inc_n, hit;
    logic                 clr_n;

    // A draw is accepted as a round but awards no points.
    assign inc_vec = (sk.WINNER_DISP == W_DRAW) ? W_NONE : sk.WINNER_DISP;
    assign hit = {sat_next(score_a, |(inc_vec & W_A)) >= TGT,
                  sat_next(score_b, |(inc_vec & W_B)) >= TGT,
                  sat_next(score_c, |(inc_vec & W_C)) >= TGT};

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_WAIT;
            round_cnt  <= '0;
            round_done <= 1'b0;
            match_over <= 1'b0;
            champ      <= W_NONE;
        end else begin
            state      <= state_n;
            round_cnt  <= round_cnt_n;
            round_done <= round_done_n;
            match_over <= match_over_n;
            champ      <= champ_n;
        end
    end

    always_comb begin
        state_n      = state;
        round_cnt_n  = round_cnt;
        round_done_n = 1'b0;
        match_over_n = match_over;
        champ_n      = champ;
        inc_n        = W_NONE;
        clr_n        = 1'b0;
        if (sk.NEW_MATCH) begin
            // Land in S_WAIT so a code still on the bus is not counted.
            clr_n        = 1'b1;
            state_n      = S_WAIT;
            round_cnt_n  = '0;
            match_over_n = 1'b0;
            champ_n      = W_NONE;
        end else begin
            case (state)
                S_READY: begin
                    if (sk.WINNER_DISP != W_NONE) begin
                        inc_n        = inc_vec;
                        round_cnt_n  = round_cnt + RW'(1);
                        round_done_n = 1'b1;
                        if (|hit) begin
                            state_n      = S_OVER;
                            match_over_n = 1'b1;
                            champ_n      = hit;
                        end else begin
                            state_n = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (sk.WINNER_DISP == W_NONE) state_n = S_READY;
                end
                S_OVER: begin
                    state_n = S_OVER;
                end
                default: begin
                    state_n = S_WAIT;
                end
            endcase
        end
    end

    sat_counter u_cnt_a (.CLK(CLK), .clr(RST | clr_n), .inc(|(inc_n & W_A)), .count(score_a));
    sat_counter u_cnt_b (.CLK(CLK), .clr(RST | clr_n), .inc(|(inc_n & W_B)), .count(score_b));
    sat_counter u_cnt_c (.CLK(CLK), .clr(RST | clr_n), .inc(|(inc_n & W_C)), .count(score_c));

    assign sk.SCORE_A    = score_a;
    assign sk.SCORE_B    = score_b;
    assign sk.SCORE_C    = score_c;
    assign sk.ROUND_CNT  = round_cnt;
    assign sk.ROUND_DONE = round_done;
    assign sk.MATCH_OVER = match_over;
    assign sk.CHAMP      = champ;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - directed self-checking bench for score_keeper
module tb_score_keeper;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    score_keeper_if #(.RW(6)) sk ();

    score_keeper #(.TARGET(3), .RW(6)) dut (
        .CLK (CLK),
        .RST (RST),
        .sk  (sk.slave)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [5:0] rc, input logic rd,
                           input logic mo, input logic [2:0] ch);
        chk({tag, ".score_a"},    32'(sk.SCORE_A),    32'(a));
        chk({tag, ".score_b"},    32'(sk.SCORE_B),    32'(b));
        chk({tag, ".score_c"},    32'(sk.SCORE_C),    32'(c));
        chk({tag, ".round_cnt"},  32'(sk.ROUND_CNT),  32'(rc));
        chk({tag, ".round_done"}, 32'(sk.ROUND_DONE), 32'(rd));
        chk({tag, ".match_over"}, 32'(sk.MATCH_OVER), 32'(mo));
        chk({tag, ".champ"},      32'(sk.CHAMP),      32'(ch));
    endtask

    initial begin
        RST = 1'b1;
        sk.WINNER_DISP = 3'b000;
        sk.NEW_MATCH = 1'b0;
        step();
        step();
        chk_all("reset", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        RST = 1'b0;
        step();

        // single A win
        sk.WINNER_DISP = 3'b100; step();
        chk_all("a_win", 4'd1, 4'd0, 4'd0, 6'd1, 1'b1, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();
        chk("a_win.rd_drop", 32'(sk.ROUND_DONE), 32'd0);

        // held 011 counts once
        sk.NEW_MATCH = 1'b1; step();
        sk.NEW_MATCH = 1'b0;
        chk_all("nm1", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        step();
        sk.WINNER_DISP = 3'b011; step();
        chk_all("bc_first", 4'd0, 4'd1, 4'd1, 6'd1, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bc_hold.rd", 32'(sk.ROUND_DONE), 32'd0);
        end
        sk.WINNER_DISP = 3'b000; step();
        chk_all("bc_end", 4'd0, 4'd1, 4'd1, 6'd1, 1'b0, 1'b0, 3'b000);

        // draw then A
        sk.NEW_MATCH = 1'b1; step();
        sk.NEW_MATCH = 1'b0; step();
        sk.WINNER_DISP = 3'b111; step();
        chk_all("draw", 4'd0, 4'd0, 4'd0, 6'd1, 1'b1, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b100; step();
        chk_all("after_draw", 4'd1, 4'd0, 4'd0, 6'd2, 1'b1, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();

        // drive A and B to 2, then joint win
        sk.WINNER_DISP = 3'b010; step();
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b110; step();
        chk_all("ab_two", 4'd2, 4'd2, 4'd0, 6'd4, 1'b1, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b110; step();
        chk_all("ab_champ", 4'd3, 4'd3, 4'd0, 6'd5, 1'b1, 1'b1, 3'b110);
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b001; step();
        chk_all("over_hold", 4'd3, 4'd3, 4'd0, 6'd5, 1'b0, 1'b1, 3'b110);
        sk.WINNER_DISP = 3'b000; step();
        chk_all("over_hold2", 4'd3, 4'd3, 4'd0, 6'd5, 1'b0, 1'b1, 3'b110);

        // NEW_MATCH with simultaneous result
        sk.NEW_MATCH = 1'b1; sk.WINNER_DISP = 3'b100; step();
        sk.NEW_MATCH = 1'b0;
        chk_all("nm_collide", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        step();
        step();
        chk_all("nm_stale", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b100; step();
        chk_all("nm_rearm", 4'd1, 4'd0, 4'd0, 6'd1, 1'b1, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();

        // reset mid-round with 2/1/0
        sk.WINNER_DISP = 3'b110; step();
        chk_all("pre_rst", 4'd2, 4'd1, 4'd0, 6'd2, 1'b1, 1'b0, 3'b000);
        RST = 1'b1; step();
        RST = 1'b0;
        chk_all("mid_rst", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        step();
        chk_all("rst_stale", 4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 3'b000);
        sk.WINNER_DISP = 3'b000; step();
        sk.WINNER_DISP = 3'b001; step();
        chk_all("rst_rearm", 4'd0, 4'd0, 4'd1, 6'd1, 1'b1, 1'b0, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter TARGET, default 3: points a player needs to win the match; legal range 1..15.
REQ-002 SHALL have parameter RW, default 6: width of the round counter.
REQ-003 SHALL have port CLK, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port WINNER_DISP, input, 3 bits: round-result code from the game FSM; bit2=A, bit1=B, bit0=C; 000 = no result; 111 = draw.
REQ-006 SHALL have port NEW_MATCH, input, 1 bit: level-sampled request to clear scores and start a new match.
REQ-007 SHALL have ports SCORE_A, SCORE_B, SCORE_C, output, 4 bits each: registered per-player points.
REQ-008 SHALL have port ROUND_CNT, output, RW bits: registered count of accepted results, draws included.
REQ-009 SHALL have port ROUND_DONE, output, 1 bit: one-cycle pulse per accepted result.
REQ-010 SHALL have port MATCH_OVER, output, 1 bit: registered; high while the match is decided.
REQ-011 SHALL have port CHAMP, output, 3 bits: registered, same bit mapping as WINNER_DISP; set bits mark players at or above TARGET.

Function
REQ-012 SHALL implement the FSM states S_READY (armed), S_WAIT (result taken, waiting for code 000) and S_OVER (match decided).
REQ-013 SHALL, in S_READY with WINNER_DISP != 000, accept the code at that edge and go to S_WAIT, or to S_OVER if TARGET is reached.
REQ-014 SHALL stay in S_WAIT while WINNER_DISP != 000 and return to S_READY on the first edge that samples 000, so a held code counts exactly once.
REQ-015 SHALL, on acceptance of any non-draw code, add one point to every player whose bit is set (for example 110 scores A and B) in the same edge.
REQ-016 SHALL, on acceptance of a draw (111), change no score and only increment ROUND_CNT.
REQ-017 SHALL increment ROUND_CNT by 1 on every acceptance and wrap modulo 2^RW.
REQ-018 SHALL pulse ROUND_DONE high for exactly the one cycle after each accepting edge; scores are visible in that same cycle (latency 1).
REQ-019 SHALL saturate scores at 15 and never wrap them.
REQ-020 SHALL set MATCH_OVER and CHAMP at the accepting edge on which any updated score reaches TARGET.
REQ-021 SHALL set every CHAMP bit whose updated score is >= TARGET when several players reach TARGET at the same edge.
REQ-022 SHALL, in S_OVER, ignore WINNER_DISP and hold all scores, ROUND_CNT, CHAMP and MATCH_OVER.
REQ-023 SHALL, on NEW_MATCH=1 in any state, clear scores, ROUND_CNT, CHAMP and MATCH_OVER and enter S_WAIT, which prevents counting a stale code.
REQ-024 SHALL, when NEW_MATCH and a result arrive at the same edge, obey NEW_MATCH and drop the result (no ROUND_DONE).

Reset
REQ-025 SHALL, on RST=1 sampled at an edge, set state S_WAIT, SCORE_A, SCORE_B and SCORE_C to 0, ROUND_CNT to 0, ROUND_DONE to 0, MATCH_OVER to 0 and CHAMP to 000.
REQ-026 SHALL give RST priority over NEW_MATCH and WINNER_DISP, and reset mid-round SHALL discard any pending result.

Structure
REQ-027 SHALL place the winner-code constants (W_NONE=000, W_A=100, W_B=010, W_C=001, W_DRAW=111), the state encodings and the score width (4) in shared package hgame_pkg.
REQ-028 SHALL instantiate sub-module sat_counter three times (4-bit, with inputs inc and clr, saturating at 15), one instance per player.

Verification
REQ-029 SHALL cover: reset, then WINNER_DISP=100 for 1 cycle then 000 -> SCORE_A=1, ROUND_CNT=1, ROUND_DONE high exactly 1 cycle.
REQ-030 SHALL cover: WINNER_DISP=011 held 4 cycles then 000 -> SCORE_B=1, SCORE_C=1, ROUND_CNT=1, a single ROUND_DONE.
REQ-031 SHALL cover: WINNER_DISP=111, then 000, then 100, then 000 -> all scores 0 after the draw, ROUND_CNT=1, then SCORE_A=1, ROUND_CNT=2.
REQ-032 SHALL cover: TARGET=3 with A and B both at 2, then code 110 -> MATCH_OVER=1, CHAMP=110 at that edge; a following code 001 is ignored (SCORE_C stays 0, ROUND_CNT unchanged).
REQ-033 SHALL cover: NEW_MATCH=1 at the same edge as code 100 -> all outputs 0, no ROUND_DONE; code 100 held afterwards is not counted until 000 is seen.
REQ-034 SHALL cover: RST asserted in S_WAIT with scores 2/1/0 -> all outputs 0 on the next cycle, and the held code is not counted.
